regbank_write_arbiter: RTL and testbench

//  Write-back stage directly upstream of register_bank. Merges two write-back ports per

---
 rtl/nl16_pkg.sv | 24 ++
 rtl/wb_skid_fifo.sv | 58 +++++
 rtl/regbank_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regbank_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nl16_pkg.sv
// Shared types and constants for the write-back arbiter and its skid buffer.
package nl16_pkg;

  localparam int unsigned NREG   = 16;
  localparam int unsigned DW     = 32;
  localparam int unsigned REG_AW = 4;

  // One write-back request: destination register and data.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [DW-1:0]     data;
  } wb_req_t;

  // One-hot register select, all-zero when the request is not valid.
  function automatic logic [NREG-1:0] reg_onehot(input logic valid,
                                                 input logic [REG_AW-1:0] addr);
    logic [NREG-1:0] oh;
    oh = '0;
    if (valid) oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Circular skid buffer for port-B write requests; head is shown combinationally.
module wb_skid_fifo
  import nl16_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  wb_req_t i_data,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_req_t         r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  // Pointers wrap modulo Depth, so non-power-of-two depths also work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & !o_empty;
  // A pop frees the head slot, so a push into a full buffer is fine in that cycle.
  assign w_push  = i_push & (!o_full | w_pop);
  assign o_head  = r_mem[r_rd_ptr];

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Write-back arbiter: merges ALU (A) and load (B) writes into the register bank's
// D/hold inputs, sequencing same-register collisions so the younger B lands last.
module regbank_write_arbiter
  import nl16_pkg::*;
#(
  parameter int unsigned BDEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_a_valid,
  input  logic [REG_AW-1:0]    i_a_addr,
  input  logic [DW-1:0]        i_a_data,
  output logic                 o_a_ready,
  input  logic                 i_b_valid,
  input  logic [REG_AW-1:0]    i_b_addr,
  input  logic [DW-1:0]        i_b_data,
  output logic                 o_b_ready,
  input  logic                 i_hset_valid,
  input  logic [REG_AW-1:0]    i_hset_addr,
  input  logic [NREG*DW-1:0]   i_bank_q,
  input  logic [NREG-1:0]      i_bank_hold_q,
  output logic [NREG*DW-1:0]   o_bank_d,
  output logic [NREG-1:0]      o_bank_hold_d,
  output logic                 o_bank_en
);

  logic    r_live;
  wb_req_t r_s1_a;
  wb_req_t r_s1_b;

  logic    w_rst;
  logic    w_collide;
  logic    w_a_acc;
  logic    w_b_acc;
  wb_req_t w_b_req;
  wb_req_t w_s1_a_d;
  wb_req_t w_s1_b_d;
  logic    w_fifo_push;
  logic    w_fifo_pop;
  wb_req_t w_fifo_head;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic [NREG-1:0] w_dec_a;
  logic [NREG-1:0] w_dec_b;
  logic [NREG-1:0] w_dec_set;
  logic [NREG-1:0] w_commit;

  // Reset values persist for the first cycle after Reset drops (r_live still low).
  assign w_rst     = i_reset | !r_live;
  assign w_collide = r_s1_a.valid & r_s1_b.valid & (r_s1_a.addr == r_s1_b.addr);

  // While B is held behind a collision, a new A to the same register would overtake it.
  assign o_a_ready = !w_rst & !(w_collide & (i_a_addr == r_s1_b.addr));
  assign o_b_ready = !w_rst & !w_fifo_full;
  assign w_a_acc   = i_a_valid & o_a_ready;
  assign w_b_acc   = i_b_valid & o_b_ready;

  assign w_b_req  = '{valid: 1'b1, addr: i_b_addr, data: i_b_data};
  assign w_s1_a_d = '{valid: w_a_acc, addr: i_a_addr, data: i_a_data};

  // B slot source: held B, else buffer head, else the new input directly.
  always_comb begin
    w_s1_b_d   = '0;
    w_fifo_pop = 1'b0;
    if (w_collide) begin
      w_s1_b_d = r_s1_b;
    end else if (!w_fifo_empty) begin
      w_s1_b_d   = w_fifo_head;
      w_fifo_pop = 1'b1;
    end else if (w_b_acc) begin
      w_s1_b_d = w_b_req;
    end
    w_fifo_push = w_b_acc & (w_collide | !w_fifo_empty);
  end

  wb_skid_fifo #(
    .Depth (BDEPTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_fifo_push),
    .i_data  (w_b_req),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Stage register S1 and the post-reset live flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_live <= 1'b0;
      r_s1_a <= '0;
      r_s1_b <= '0;
    end else begin
      r_live <= 1'b1;
      r_s1_a <= w_s1_a_d;
      r_s1_b <= w_s1_b_d;
    end
  end

  assign w_dec_a   = reg_onehot(r_s1_a.valid, r_s1_a.addr);
  assign w_dec_b   = reg_onehot(r_s1_b.valid & !w_collide, r_s1_b.addr);
  assign w_dec_set = reg_onehot(i_hset_valid, i_hset_addr);
  assign w_commit  = w_dec_a | w_dec_b;

  // Per-register D mux (B over A over current value) and hold scoreboard.
  always_comb begin
    o_bank_d = i_bank_q;
    for (int i = 0; i < NREG; i++) begin
      if (w_dec_b[i])      o_bank_d[i*DW +: DW] = r_s1_b.data;
      else if (w_dec_a[i]) o_bank_d[i*DW +: DW] = r_s1_a.data;
    end
    // Set is ORed in last so a same-cycle set beats the commit's clear.
    o_bank_hold_d = (i_bank_hold_q & ~w_commit) | w_dec_set;
    o_bank_en     = (|w_commit) | (o_bank_hold_d != i_bank_hold_q);
    if (w_rst) begin
      o_bank_d      = '0;
      o_bank_hold_d = '0;
      o_bank_en     = 1'b1;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios plus a randomized phase checked
// against a register-file model; the register bank itself is modelled here.
module tb_regbank_write_arbiter;
  import nl16_pkg::*;

  localparam int unsigned BW = NREG * DW;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, a_ready, b_valid, b_ready, hset_valid, bank_en;
  logic [REG_AW-1:0] a_addr, b_addr, hset_addr;
  logic [DW-1:0]     a_data, b_data;
  logic [BW-1:0]     bank_q, bank_d;
  logic [NREG-1:0]   hold_q, hold_d;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic acc_a, acc_b, br_neg;

  logic [DW-1:0]     m [NREG];
  logic [NREG-1:0]   mh;
  logic [BW-1:0]     exp_v;
  logic [DW-1:0]     qa[$], qb[$], seen[$], want[$];
  logic [DW-1:0]     prev;
  logic              saw, full, pa_v;
  logic [REG_AW-1:0] pa_addr;
  logic [DW-1:0]     pa_data;

  always #5 clk = ~clk;

  regbank_write_arbiter #(
    .BDEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_a_valid     (a_valid),
    .i_a_addr      (a_addr),
    .i_a_data      (a_data),
    .o_a_ready     (a_ready),
    .i_b_valid     (b_valid),
    .i_b_addr      (b_addr),
    .i_b_data      (b_data),
    .o_b_ready     (b_ready),
    .i_hset_valid  (hset_valid),
    .i_hset_addr   (hset_addr),
    .i_bank_q      (bank_q),
    .i_bank_hold_q (hold_q),
    .o_bank_d      (bank_d),
    .o_bank_hold_d (hold_d),
    .o_bank_en     (bank_en)
  );

  // Register bank downstream of the arbiter.
  always @(posedge clk) begin
    if (bank_en) begin
      bank_q <= bank_d;
      hold_q <= hold_d;
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc_a  = a_valid & a_ready;
    acc_b  = b_valid & b_ready;
    br_neg = b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid    = 1'b0;
    b_valid    = 1'b0;
    hset_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return bank_q[i*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] pack_model(input int n);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*DW +: DW] = m[i];
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    a_addr = '0; b_addr = '0; hset_addr = '0; a_data = '0; b_data = '0;

    // Reset
    repeat (3) tick();
    check("rst_bank_d", bank_d, '0);
    check("rst_hold_d", BW'(hold_d), '0);
    check("rst_ready", BW'({a_ready, b_ready}), '0);
    check("rst_en", BW'(bank_en), BW'(1));
    reset = 1'b0;
    tick();
    check("live_ready", BW'({a_ready, b_ready}), BW'(2'b11));
    check("live_bank", bank_q, '0);

    // Dual write, distinct registers
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_addr = 4'd7; b_data = 32'h2222_2222;
    tick();
    check("dual_acc", BW'({acc_a, acc_b}), BW'(2'b11));
    idle();
    check("dual_not_yet", bank_q, '0);
    tick();
    exp_v = '0;
    exp_v[3*DW +: DW] = 32'h1111_1111;
    exp_v[7*DW +: DW] = 32'h2222_2222;
    check("dual_bank", bank_q, exp_v);

    // Collision on r5
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'hAAAA_0000;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 32'h0000_BBBB;
    tick();
    idle();
    a_addr = 4'd5; #1;
    check("stall_same_reg", BW'(a_ready), '0);
    a_addr = 4'd6; #1;
    check("no_stall_other", BW'(a_ready), BW'(1));
    tick();
    check("coll_a_first", BW'(rd(5)), BW'(32'hAAAA_0000));
    tick();
    check("coll_b_last", BW'(rd(5)), BW'(32'h0000_BBBB));

    // Backpressure: four colliding pairs on r5
    for (int k = 1; k <= 4; k++) begin
      qa.push_back(32'hA000_0000 + k);
      qb.push_back(32'hB000_0000 + k);
      want.push_back(32'hA000_0000 + k);
      want.push_back(32'hB000_0000 + k);
    end
    saw  = 1'b0;
    prev = rd(5);
    for (int t = 0; t < 40; t++) begin
      idle();
      a_addr = 4'd5; b_addr = 4'd5;
      if (qa.size() != 0) begin a_valid = 1'b1; a_data = qa[0]; end
      if (qb.size() != 0) begin b_valid = 1'b1; b_data = qb[0]; end
      tick();
      if (!br_neg) saw = 1'b1;
      if (acc_a) qa.delete(0);
      if (acc_b) qb.delete(0);
      if (rd(5) !== prev) begin
        seen.push_back(rd(5));
        prev = rd(5);
      end
    end
    idle();
    check("bp_drained", BW'(qa.size() + qb.size()), '0);
    check("bp_b_stalled", BW'(saw), BW'(1));
    check("bp_commit_count", BW'(seen.size()), BW'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < seen.size()) check($sformatf("bp_order%0d", k), BW'(seen[k]), BW'(want[k]));
    end

    // Hold scoreboard
    hset_valid = 1'b1; hset_addr = 4'd9; #1;
    check("hset_en", BW'(bank_en), BW'(1));
    tick();
    hset_valid = 1'b0;
    check("hset_visible", BW'(hold_q), BW'(16'h0200));
    b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h9999_9999;
    tick();
    idle();
    tick();
    check("hold_cleared", BW'(hold_q), '0);
    check("hold_write", BW'(rd(9)), BW'(32'h9999_9999));
    hset_valid = 1'b1; hset_addr = 4'd9;
    tick();
    hset_valid = 1'b0;
    b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h7777_7777;
    tick();
    idle();
    hset_valid = 1'b1; hset_addr = 4'd9;
    tick();
    hset_valid = 1'b0; #1;
    check("set_wins", BW'(hold_q), BW'(16'h0200));
    check("set_wins_data", BW'(rd(9)), BW'(32'h7777_7777));
    check("idle_en", BW'(bank_en), '0);

    // Mid-operation reset with a full skid buffer
    full = 1'b0;
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'hC000_0001;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 32'hD000_0001;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (acc_a) a_data = a_data + 1;
      if (acc_b) b_data = b_data + 1;
      if (!b_ready) begin
        full = 1'b1;
        break;
      end
    end
    check("mid_full", BW'(full), BW'(1));
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("mid_bank", bank_q, '0);
    check("mid_hold", BW'(hold_q), '0);
    check("mid_b_ready", BW'(b_ready), BW'(1));
    b_valid = 1'b1; b_addr = 4'd1; b_data = 32'h1234_5678;
    tick();
    idle();
    tick();
    check("mid_fresh_b", BW'(rd(1)), BW'(32'h1234_5678));

    // Randomized: A writes r0..r7 (fixed 2-cycle latency), B writes r8..r15
    for (int i = 0; i < NREG; i++) m[i] = '0;
    m[1] = 32'h1234_5678;
    mh   = '0;
    pa_v = 1'b0; pa_addr = '0; pa_data = '0;
    for (int t = 0; t < 300; t++) begin
      a_valid    = ($urandom_range(0, 3) != 0);
      a_addr     = REG_AW'($urandom_range(0, 7));
      a_data     = $urandom;
      b_valid    = ($urandom_range(0, 1) != 0);
      b_addr     = REG_AW'($urandom_range(8, 15));
      b_data     = $urandom;
      hset_valid = ($urandom_range(0, 3) == 0);
      hset_addr  = REG_AW'($urandom_range(0, 7));
      tick();
      if (pa_v) begin
        m[pa_addr]  = pa_data;
        mh[pa_addr] = 1'b0;
      end
      if (hset_valid) mh[hset_addr] = 1'b1;
      pa_v = acc_a; pa_addr = a_addr; pa_data = a_data;
      if (acc_b) m[b_addr] = b_data;
      check("rnd_a_ready", BW'(acc_a), BW'(a_valid));
      check("rnd_a_bank", BW'(bank_q[8*DW-1:0]), pack_model(8));
      check("rnd_a_hold", BW'(hold_q), BW'(mh));
    end
    idle();
    for (int t = 0; t < 10; t++) begin
      tick();
      if (pa_v) begin
        m[pa_addr]  = pa_data;
        mh[pa_addr] = 1'b0;
      end
      pa_v = 1'b0;
    end
    check("rnd_final_bank", bank_q, pack_model(NREG));
    check("rnd_final_hold", BW'(hold_q), BW'(mh));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
